// File: rtl/seg7_scan_if.sv
// Sample-in / segment-out bundle for seg7_scan_display.
// The master drives the sample and strobe; the slave (display) drives busy and the scan outputs.
interface seg7_scan_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIGITS = 4
) ();
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              mode_dec;
    logic              busy;
    logic [6:0]        seg_out;
    logic [DIGITS-1:0] dig_sel;

    modport master (
        output data_in, data_valid, mode_dec,
        input  busy, seg_out, dig_sel
    );

    modport slave (
        input  data_in, data_valid, mode_dec,
        output busy, seg_out, dig_sel
    );
endinterface

// File: rtl/seg7_scan_display.sv
// Hex / unsigned-decimal (double dabble) sample display on DIGITS multiplexed 7-segment digits.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_display #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000
) (
    input logic       clk,
    input logic       rst_n,
    seg7_scan_if.slave bus
);
    localparam int unsigned BcdN = (DATA_W + 2) / 3;
    localparam int unsigned BcdW = 4 * BcdN;
    localparam int unsigned PadN = (BcdN > DIGITS) ? BcdN : DIGITS;
    localparam int unsigned ItW  = $clog2(DATA_W);
    localparam int unsigned CntW = $clog2(SCAN_DIV);
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0] SegDash  = 7'b0111111;
    localparam logic [6:0] SegBlank = 7'b1111111;

    typedef enum logic [1:0] {StIdle, StConvert, StLoad} state_e;

    state_e                   state_q, state_d;
    logic [DATA_W-1:0]        bin_q, bin_d;
    logic [BcdW-1:0]          bcd_q, bcd_d, bcd_adj;
    logic [ItW-1:0]           it_q, it_d;
    logic                     mode_q, mode_d;
    logic                     load;

    logic [4*PadN-1:0]        src;
    logic [DIGITS-1:0][3:0]   dig_q, dig_d;
    logic                     ovf_q, ovf_d;

    logic [CntW-1:0]          cnt_q;
    logic [IdxW-1:0]          idx_q;
    logic [6:0]               seg_q, seg_cur;
    logic [DIGITS-1:0]        sel_q;

    function automatic logic [6:0] enc(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Add-3 correction applied to every BCD nibble before the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(BcdN); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        it_d    = it_q;
        mode_d  = mode_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.data_valid) begin
                    bin_d   = bus.data_in;
                    mode_d  = bus.mode_dec;
                    bcd_d   = '0;
                    it_d    = '0;
                    state_d = bus.mode_dec ? StConvert : StLoad;
                end
            end
            StConvert: begin
                bcd_d = {bcd_adj[BcdW-2:0], bin_q[DATA_W-1]};
                bin_d = {bin_q[DATA_W-2:0], 1'b0};
                it_d  = it_q + 1'b1;
                if (it_q == ItW'(DATA_W - 1)) state_d = StLoad;
            end
            StLoad: begin
                load    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Source nibbles zero-padded to cover every physical digit
    always_comb begin
        src            = '0;
        src[BcdW-1:0]  = mode_q ? bcd_q : {{(BcdW - DATA_W){1'b0}}, bin_q};
        ovf_d          = 1'b0;
        for (int i = int'(DIGITS); i < int'(PadN); i++) begin
            if (src[4*i +: 4] != 4'h0) ovf_d = 1'b1;
        end
        for (int i = 0; i < int'(DIGITS); i++) dig_d[i] = src[4*i +: 4];
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              lead;

    // Digit 0 is never blanked so a zero value still shows one "0"
    always_comb begin
        blank_d = '0;
        lead    = 1'b1;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            if (dig_d[i] != 4'h0) lead = 1'b0;
            blank_d[i] = lead;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    blank_q <= '0;
        else if (load) blank_q <= blank_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            bin_q   <= '0;
            bcd_q   <= '0;
            it_q    <= '0;
            mode_q  <= 1'b0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            it_q    <= it_d;
            mode_q  <= mode_d;
            if (load) begin
                dig_q <= dig_d;
                ovf_q <= ovf_d;
            end
        end
    end

    always_comb begin
        seg_cur = enc(dig_q[idx_q]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (blank_q[idx_q]) seg_cur = SegBlank;
`endif
        if (ovf_q) seg_cur = SegDash;
    end

    // Segments and enable are registered on the same wrap edge so they never disagree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            seg_q <= SegBlank;
            sel_q <= '0;
        end else if (cnt_q == CntW'(SCAN_DIV - 1)) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            seg_q <= seg_cur;
            sel_q <= DIGITS'(1) << idx_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.busy    = (state_q != StIdle);
    assign bus.seg_out = seg_q;
    assign bus.dig_sel = sel_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: a 4-digit and a 2-digit instance driven in lockstep.
module tb_seg7_scan_display;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SD = 7'b0111111;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = S0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seg7_scan_if #(.DATA_W(8), .DIGITS(4)) ifa ();
    seg7_scan_if #(.DATA_W(8), .DIGITS(2)) ifb ();

    seg7_scan_display #(.DATA_W(8), .DIGITS(4), .SCAN_DIV(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    seg7_scan_display #(.DATA_W(8), .DIGITS(2), .SCAN_DIV(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic m, input logic v);
        ifa.data_in = d;  ifb.data_in = d;
        ifa.mode_dec = m; ifb.mode_dec = m;
        ifa.data_valid = v; ifb.data_valid = v;
    endtask

    // Returns on the negedge right after the capture edge (first busy cycle)
    task automatic send(input logic [7:0] d, input logic m);
        @(negedge clk);
        drive(d, m, 1'b1);
        @(negedge clk);
        ifa.data_valid = 1'b0; ifb.data_valid = 1'b0;
    endtask

    task automatic busy_len(input string tag, input int exp);
        int n = 0;
        while (ifa.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check(tag, n, exp);
    endtask

    task automatic scan_check(input string tag, input bit use_b,
                              input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] exp_seg [4];
        logic [3:0] sel;
        logic [6:0] seg;
        bit         found;
        int         nd;
        exp_seg = '{e0, e1, e2, e3};
        nd = use_b ? 2 : 4;
        seg = '0;
        repeat (18) @(negedge clk);
        for (int j = 0; j < nd; j++) begin
            found = 1'b0;
            for (int t = 0; t < 20 && !found; t++) begin
                @(negedge clk);
                sel = use_b ? {2'b00, ifb.dig_sel} : ifa.dig_sel;
                seg = use_b ? ifb.seg_out : ifa.seg_out;
                if (sel == 4'(1 << j)) found = 1'b1;
            end
            check($sformatf("%s_sel%0d", tag, j), {31'b0, found}, 32'd1);
            check($sformatf("%s_seg%0d", tag, j), {25'b0, seg}, {25'b0, exp_seg[j]});
        end
    endtask

    initial begin
        int n;
        drive(8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_seg_a", {25'b0, ifa.seg_out}, 32'h7F);
        check("rst_sel_a", {28'b0, ifa.dig_sel}, 32'h0);
        check("rst_sel_b", {30'b0, ifb.dig_sel}, 32'h0);
        check("rst_busy", {31'b0, ifa.busy}, 32'h0);
        rst_n = 1'b1;
        scan_check("rst_scan_a", 1'b0, S0, S0, S0, S0);
        scan_check("rst_scan_b", 1'b1, S0, S0, S0, S0);

        send(8'hA7, 1'b0);
        busy_len("hex_busy", 1);
        scan_check("hex_a7", 1'b0, S7, SA, LZ, LZ);

        send(8'd255, 1'b1);
        busy_len("dec_busy", 9);
        scan_check("dec_255", 1'b0, S5, S5, S2, LZ);
        scan_check("dec_255_b", 1'b1, SD, SD, SD, SD);

        send(8'd200, 1'b1);
        busy_len("ovf_busy", 9);
        scan_check("ovf_200_b", 1'b1, SD, SD, SD, SD);
        scan_check("dec_200_a", 1'b0, S0, S0, S2, LZ);

        send(8'h3C, 1'b0);
        busy_len("hex3c_busy", 1);
        scan_check("hex_3c_b", 1'b1, SC, S3, SD, SD);
        scan_check("hex_3c_a", 1'b0, SC, S3, LZ, LZ);

        // Second strobe on busy cycle 3 must be dropped
        send(8'd99, 1'b1);
        n = 0;
        while (ifa.busy && n < 40) begin
            n++;
            drive(8'd11, 1'b0, n == 3);
            @(negedge clk);
        end
        drive(8'd11, 1'b0, 1'b0);
        check("drop_busy", n, 9);
        scan_check("drop_99", 1'b0, S9, S9, LZ, LZ);

        send(8'd255, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_seg", {25'b0, ifa.seg_out}, 32'h7F);
        check("mid_rst_sel", {28'b0, ifa.dig_sel}, 32'h0);
        check("mid_rst_busy", {31'b0, ifa.busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {31'b0, ifa.busy}, 32'h0);
        scan_check("post_rst", 1'b0, S0, S0, S0, S0);

        send(8'd0, 1'b1);
        n = 0;
        while (ifa.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("b2b_first_busy", n, 9);
        drive(8'hFF, 1'b0, 1'b1);
        @(negedge clk);
        drive(8'hFF, 1'b0, 1'b0);
        check("b2b_accept", {31'b0, ifa.busy}, 32'h1);
        busy_len("b2b_busy", 1);
        scan_check("b2b_ff", 1'b0, SF, SF, LZ, LZ);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised successor to the per-digit hex 7-segment decoder on the PCF8591 ADC readout path.
- Accepts a DATA_W-bit sample on a valid strobe and displays it as hex or unsigned decimal on DIGITS time-multiplexed digits.
- Decimal conversion is sequential shift-and-add-3 (double dabble).
- Sits between the I2C/ADC capture logic and the board's shared-segment display.

Parameters:
- DATA_W, 8, sample width in bits (4..16).
- DIGITS, 4, number of physical digits (1..8).
- SCAN_DIV, 50000, clocks each digit stays lit before the scan advances (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock domain; reset is asynchronous and active-low.
- data_in  in  DATA_W  sample to display.
- data_valid  in  1  single-cycle strobe qualifying data_in and mode_dec.
- mode_dec  in  1  0 = hex display, 1 = unsigned decimal display.
- busy  out  1  high while a conversion is in progress; data_valid is ignored while busy is high.
- seg_out  out  7  active-low segments {g,f,e,d,c,b,a}; 0 = 7'b1000000, F = 7'b0001110, dash = 7'b0111111, blank = 7'b1111111.
- dig_sel  out  DIGITS  one-hot, active-high digit enable; bit 0 = least significant digit.

Behaviour:
- Reset values:
  - State = IDLE, busy = 0.
  - All digit registers hold value 0, overflow flag = 0.
  - seg_out = 7'b1111111, dig_sel = 0.
  - Scan counter = 0, digit index = 0.
- FSM states: IDLE, CONVERT, LOAD.
  - IDLE: on data_valid=1 at edge k, capture data_in into the shift register and latch mode_dec; clear the BCD accumulator; busy=1 from edge k. Next state is CONVERT if mode_dec=1, else LOAD.
  - CONVERT: DATA_W iterations, one per clock (edges k+1 .. k+DATA_W). Each iteration: add 3 to every BCD nibble >=5, then shift {bcd, bin} left by 1. Then go to LOAD.
  - LOAD: one clock. Write all digit registers and the overflow flag atomically, set busy=0, return to IDLE.
  - Hex latency: display registers updated at edge k+1.
  - Decimal latency: display registers updated at edge k+DATA_W+1.
- BCD accumulator width: ceil(DATA_W/3) nibbles. Hex source width: ceil(DATA_W/4) nibbles, zero-extended.
- Overflow: if any source nibble above index DIGITS-1 is nonzero, set the overflow flag; all digits then display dash. Otherwise digit i shows source nibble i, and digits beyond the source width show 0.
- Displayed digits never show a partially converted value; digit registers change only in LOAD.
- Scanning:
  - Scan counter counts 0..SCAN_DIV-1 and wraps. On wrap, the digit index advances and wraps from DIGITS-1 to 0.
  - Each wrap registers seg_out = encoding of digit[index] and dig_sel = one-hot(index) on the same edge, so segments and enable are never mismatched.
  - Scanning is independent of the FSM and continues during conversion.
- data_valid while busy: dropped, no effect, no queueing.
- data_valid in the same cycle LOAD completes: ignored. It is accepted only when sampled in IDLE.
- rst_n asserted mid-conversion: immediately returns to reset values; the partial result is discarded.
- DIGITS=1: dig_sel is held at 1'b1 after the first scan wrap.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: in LOAD, every digit above the most significant nonzero digit is stored as blank (7'b1111111). Digit 0 is never blanked, so value 0 shows a single "0". Overflow dashes are never blanked.
- Undefined: leading zeros are displayed as "0"; there is no blanking logic.

Test Plan:
- Hex, DATA_W=8, DIGITS=4, SCAN_DIV=4: data_in=8'hA7, mode_dec=0 -> busy high 1 cycle; over one scan cycle the digits read 7(1111000), A(0001000), 0, 0 with dig_sel 0001,0010,0100,1000.
- Decimal: data_in=8'd255, mode_dec=1 -> busy high exactly 9 cycles; digits read 5,5,2,0 (with SEG7_LEADING_ZERO_BLANK_EN: 5,5,2,blank).
- Overflow, DIGITS=2, decimal: data_in=8'd200 -> both digits show 7'b0111111. Then hex 8'h3C -> C,3 with no overflow.
- Busy drop: 8'd99 decimal, then data_valid with 8'd11 at busy cycle 3 -> final display 9,9; the second strobe has no effect.
- Reset mid-CONVERT: rst_n low for 1 cycle at conversion cycle 4 -> seg_out=7'h7F, dig_sel=0, busy=0 immediately; the next scan shows 0 on all digits.
- Back-to-back: strobe 8'd0 decimal, then strobe 8'hFF hex the cycle after busy falls -> second value accepted; displays F,F,0,0.
